// File: rtl/avalon_host_wr_buffer.sv
// Write buffer between the AFU write engine and the host_mem write channel.
// Beats are queued in a show-ahead FIFO; new bursts are held back at the sink
// once MAX_OUTSTND bursts are awaiting a write response. Counters and an idle
// flag are exported for CSR visibility.
module avalon_host_wr_buffer #(
  parameter int ADDR_W       = 42,
  parameter int DATA_W       = 512,
  parameter int BURST_W      = 7,
  parameter int USER_W       = 1,
  parameter int DEPTH        = 16,
  parameter int MAX_OUTSTND  = 64,
  parameter bit PROTO_ERR_EN = 1'b1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             s_write,
  input  logic [ADDR_W-1:0]                s_address,
  input  logic [DATA_W-1:0]                s_writedata,
  input  logic [DATA_W/8-1:0]              s_byteenable,
  input  logic [BURST_W-1:0]               s_burstcount,
  input  logic [USER_W-1:0]                s_user,
  output logic                             s_waitrequest,
  output logic                             m_write,
  output logic [ADDR_W-1:0]                m_address,
  output logic [DATA_W-1:0]                m_writedata,
  output logic [DATA_W/8-1:0]              m_byteenable,
  output logic [BURST_W-1:0]               m_burstcount,
  output logic [USER_W-1:0]                m_user,
  input  logic                             m_waitrequest,
  input  logic                             m_wrrsp_valid,
  input  logic                             clr_stats,
  output logic [$clog2(DEPTH):0]           fifo_level,
  output logic [$clog2(MAX_OUTSTND):0]     outstanding,
  output logic [63:0]                      beats_written,
  output logic                             idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTND) + 1;
  localparam int BE_W  = DATA_W / 8;

  // Per-beat storage; contents are never reset, validity comes from the level.
  logic [ADDR_W-1:0]  addr_mem [DEPTH];
  logic [DATA_W-1:0]  data_mem [DEPTH];
  logic [BE_W-1:0]    be_mem   [DEPTH];
  logic [BURST_W-1:0] bc_mem   [DEPTH];
  logic [USER_W-1:0]  user_mem [DEPTH];
  logic               sop_mem  [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [OUT_W-1:0]   outst_q, outst_d;
  logic [63:0]        bw_q, bw_d;
  // Beats remaining in the current burst; zero means the next beat is a first beat.
  logic [BURST_W-1:0] src_cnt_q, src_cnt_d;
  logic [BURST_W-1:0] snk_cnt_q, snk_cnt_d;

  logic push, pop, empty, head_sop, src_sop, at_limit, rsp_take;

  assign empty    = (level_q == '0);
  assign head_sop = sop_mem[rd_ptr_q];
  assign src_sop  = (src_cnt_q == '0);
  assign at_limit = (outst_q == OUT_W'(MAX_OUTSTND));
  assign rsp_take = m_wrrsp_valid && (outst_q != '0);

  // Backpressure is purely from the registered level, never from the sink.
  assign s_waitrequest = !reset_n || (level_q == LVL_W'(DEPTH));
  // Only a burst's first beat may be held by the outstanding limit.
  assign m_write       = reset_n && !empty && !(head_sop && at_limit);

  assign push = s_write && !s_waitrequest;
  assign pop  = m_write && !m_waitrequest;

  assign m_address     = addr_mem[rd_ptr_q];
  assign m_writedata   = data_mem[rd_ptr_q];
  assign m_byteenable  = be_mem[rd_ptr_q];
  assign m_burstcount  = bc_mem[rd_ptr_q];
  assign m_user        = user_mem[rd_ptr_q];

  assign fifo_level    = level_q;
  assign outstanding   = outst_q;
  assign beats_written = bw_q;
  assign idle          = empty && (outst_q == '0) && src_sop && (snk_cnt_q == '0);

  // Next-state for pointers, level, burst tracking and counters.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    outst_d   = outst_q;
    bw_d      = bw_q;
    src_cnt_d = src_cnt_q;
    snk_cnt_d = snk_cnt_q;

    if (push) begin
      wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      src_cnt_d = src_sop ? (s_burstcount - BURST_W'(1)) : (src_cnt_q - BURST_W'(1));
    end

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      snk_cnt_d = (snk_cnt_q == '0) ? (bc_mem[rd_ptr_q] - BURST_W'(1))
                                    : (snk_cnt_q - BURST_W'(1));
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // A response with nothing outstanding is dropped rather than underflowing.
    case ({pop && head_sop, rsp_take})
      2'b10:   outst_d = outst_q + OUT_W'(1);
      2'b01:   outst_d = outst_q - OUT_W'(1);
      default: outst_d = outst_q;
    endcase

    if (clr_stats)
      bw_d = '0;
    else if (pop)
      bw_d = bw_q + 64'd1;
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      outst_q   <= '0;
      bw_q      <= '0;
      src_cnt_q <= '0;
      snk_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      outst_q   <= outst_d;
      bw_q      <= bw_d;
      src_cnt_q <= src_cnt_d;
      snk_cnt_q <= snk_cnt_d;
    end
  end

  // Tail write of an accepted beat, tagged with its first-beat flag.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= s_address;
      data_mem[wr_ptr_q] <= s_writedata;
      be_mem[wr_ptr_q]   <= s_byteenable;
      bc_mem[wr_ptr_q]   <= s_burstcount;
      user_mem[wr_ptr_q] <= s_user;
      sop_mem[wr_ptr_q]  <= src_sop;
    end
  end

`ifndef SYNTHESIS
  generate
    if (PROTO_ERR_EN) begin : g_proto_chk
      // Flag a write response that has no outstanding burst to retire.
      always_ff @(posedge clk) begin
        if (reset_n && m_wrrsp_valid && (outst_q == '0))
          $error("avalon_host_wr_buffer: write response with no outstanding burst");
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_avalon_host_wr_buffer.sv
// Directed bench for avalon_host_wr_buffer: a per-cycle vector table for the
// basic single/burst flow, then hand-written sequences for fill, throttle,
// response accounting and mid-operation reset.
module tb_avalon_host_wr_buffer;

  localparam int ADDR_W = 42;
  localparam int DATA_W = 64;
  localparam int BURST_W = 7;
  localparam int USER_W = 1;
  localparam int DEPTH = 16;
  localparam int MAXO = 4;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 s_write;
  logic [ADDR_W-1:0]    s_address;
  logic [DATA_W-1:0]    s_writedata;
  logic [DATA_W/8-1:0]  s_byteenable;
  logic [BURST_W-1:0]   s_burstcount;
  logic [USER_W-1:0]    s_user;
  logic                 s_waitrequest;
  logic                 m_write;
  logic [ADDR_W-1:0]    m_address;
  logic [DATA_W-1:0]    m_writedata;
  logic [DATA_W/8-1:0]  m_byteenable;
  logic [BURST_W-1:0]   m_burstcount;
  logic [USER_W-1:0]    m_user;
  logic                 m_waitrequest;
  logic                 m_wrrsp_valid;
  logic                 clr_stats;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [$clog2(MAXO):0]  outstanding;
  logic [63:0]          beats_written;
  logic                 idle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avalon_host_wr_buffer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .USER_W(USER_W),
    .DEPTH(DEPTH), .MAX_OUTSTND(MAXO), .PROTO_ERR_EN(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_write(s_write), .s_address(s_address), .s_writedata(s_writedata),
    .s_byteenable(s_byteenable), .s_burstcount(s_burstcount), .s_user(s_user),
    .s_waitrequest(s_waitrequest),
    .m_write(m_write), .m_address(m_address), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_burstcount(m_burstcount), .m_user(m_user),
    .m_waitrequest(m_waitrequest), .m_wrrsp_valid(m_wrrsp_valid),
    .clr_stats(clr_stats), .fifo_level(fifo_level), .outstanding(outstanding),
    .beats_written(beats_written), .idle(idle)
  );

  typedef struct {
    logic        rst_n, wr;
    logic [15:0] addr, data;
    logic [6:0]  bc;
    logic        mwait, rsp, clr;
    logic        e_swr, e_mw;
    logic [15:0] e_addr, e_data;
    logic [6:0]  e_bc;
    int          e_lvl, e_out, e_bw;
    logic        e_idle;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(logic rst_n, logic wr, logic [15:0] addr, logic [15:0] data,
                              logic [6:0] bc, logic mwait, logic rsp, logic clr,
                              logic e_swr, logic e_mw, logic [15:0] e_addr,
                              logic [15:0] e_data, logic [6:0] e_bc, int e_lvl,
                              int e_out, int e_bw, logic e_idle);
    vec_t v;
    v.rst_n = rst_n; v.wr = wr; v.addr = addr; v.data = data; v.bc = bc;
    v.mwait = mwait; v.rsp = rsp; v.clr = clr; v.e_swr = e_swr; v.e_mw = e_mw;
    v.e_addr = e_addr; v.e_data = e_data; v.e_bc = e_bc; v.e_lvl = e_lvl;
    v.e_out = e_out; v.e_bw = e_bw; v.e_idle = e_idle;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [15:0] addr, input logic [15:0] data, input logic [6:0] bc);
    s_write = 1'b1;
    s_address = ADDR_W'(addr);
    s_writedata = DATA_W'(data);
    s_burstcount = bc;
  endtask

  initial begin
    reset_n = 1'b0; s_write = 1'b0; s_address = '0; s_writedata = '0;
    s_byteenable = '1; s_burstcount = 7'd1; s_user = 1'b1;
    m_waitrequest = 1'b0; m_wrrsp_valid = 1'b0; clr_stats = 1'b0;

    //             rst wr addr      data     bc mw rsp clr | swr mw eaddr    edata    ebc lvl out bw idle
    vecs[0]  = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0,   1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1);
    vecs[1]  = mk(1, 0, 16'h0000, 16'h0000, 1, 0, 0, 0,   0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1);
    vecs[2]  = mk(1, 1, 16'h1000, 16'h00A5, 1, 0, 0, 0,   0, 1, 16'h1000, 16'h00A5, 1, 1, 0, 0, 0);
    vecs[3]  = mk(1, 0, 16'h0000, 16'h0000, 1, 0, 0, 0,   0, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 0);
    vecs[4]  = mk(1, 0, 16'h0000, 16'h0000, 1, 0, 1, 0,   0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1);
    vecs[5]  = mk(1, 0, 16'h0000, 16'h0000, 1, 0, 0, 1,   0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1);
    vecs[6]  = mk(1, 1, 16'h2000, 16'h0011, 2, 1, 0, 0,   0, 1, 16'h2000, 16'h0011, 2, 1, 0, 0, 0);
    vecs[7]  = mk(1, 1, 16'h2040, 16'h0022, 0, 1, 0, 0,   0, 1, 16'h2000, 16'h0011, 2, 2, 0, 0, 0);
    vecs[8]  = mk(1, 0, 16'h0000, 16'h0000, 1, 0, 0, 0,   0, 1, 16'h2040, 16'h0022, 0, 1, 1, 1, 0);
    vecs[9]  = mk(1, 0, 16'h0000, 16'h0000, 1, 0, 0, 1,   0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0);
    vecs[10] = mk(1, 0, 16'h0000, 16'h0000, 1, 0, 1, 0,   0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1);

    for (int i = 0; i < 11; i++) begin
      reset_n = vecs[i].rst_n;
      s_write = vecs[i].wr;
      s_address = ADDR_W'(vecs[i].addr);
      s_writedata = DATA_W'(vecs[i].data);
      s_burstcount = vecs[i].bc;
      m_waitrequest = vecs[i].mwait;
      m_wrrsp_valid = vecs[i].rsp;
      clr_stats = vecs[i].clr;
      step();
      chk($sformatf("v%0d_swr", i), 64'(s_waitrequest), 64'(vecs[i].e_swr));
      chk($sformatf("v%0d_mwrite", i), 64'(m_write), 64'(vecs[i].e_mw));
      chk($sformatf("v%0d_level", i), 64'(fifo_level), 64'(vecs[i].e_lvl));
      chk($sformatf("v%0d_outst", i), 64'(outstanding), 64'(vecs[i].e_out));
      chk($sformatf("v%0d_bw", i), beats_written, 64'(vecs[i].e_bw));
      chk($sformatf("v%0d_idle", i), 64'(idle), 64'(vecs[i].e_idle));
      if (vecs[i].e_mw) begin
        chk($sformatf("v%0d_maddr", i), 64'(m_address), 64'(vecs[i].e_addr));
        chk($sformatf("v%0d_mdata", i), m_writedata, 64'(vecs[i].e_data));
        if (vecs[i].e_bc != 0)
          chk($sformatf("v%0d_mbc", i), 64'(m_burstcount), 64'(vecs[i].e_bc));
        chk($sformatf("v%0d_mbe", i), 64'(m_byteenable), 64'hFF);
        chk($sformatf("v%0d_muser", i), 64'(m_user), 64'h1);
      end
    end
    s_write = 1'b0; m_wrrsp_valid = 1'b0; clr_stats = 1'b0; m_waitrequest = 1'b0;

    // Fill against a stalled sink: 20 offered, 16 accepted.
    m_waitrequest = 1'b1;
    for (int i = 0; i < 20; i++) begin
      put(16'(16'h0100 + i), 16'(16'hD000 + i), 7'd1);
      step();
      chk("fill_level", 64'(fifo_level), 64'((i + 1 > 16) ? 16 : i + 1));
      chk("fill_swr", 64'(s_waitrequest), 64'(i + 1 >= 16));
      chk("fill_hold_addr", 64'(m_address), 64'h100);
    end
    // Full with a simultaneous pop: offered beat still refused that cycle.
    put(16'h0300, 16'hE000, 7'd1);
    m_waitrequest = 1'b0;
    m_wrrsp_valid = 1'b1;
    chk("rel0_addr", 64'(m_address), 64'h100);
    step();
    chk("full_pop_level", 64'(fifo_level), 64'd15);
    chk("full_pop_swr", 64'(s_waitrequest), 64'd0);
    chk("rel1_addr", 64'(m_address), 64'h101);
    step();
    chk("push_pop_level", 64'(fifo_level), 64'd15);
    s_write = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      chk("drain_mwrite", 64'(m_write), 64'd1);
      chk("drain_addr", 64'(m_address), (k < 16) ? 64'(16'h0100 + k) : 64'h300);
      chk("drain_data", m_writedata, (k < 16) ? 64'(16'hD000 + k) : 64'hE000);
      step();
    end
    chk("drain_level", 64'(fifo_level), 64'd0);
    chk("drain_mwrite_off", 64'(m_write), 64'd0);
    step();
    m_wrrsp_valid = 1'b0;
    chk("drain_outst", 64'(outstanding), 64'd0);
    chk("drain_idle", 64'(idle), 64'd1);
    chk("drain_bw", beats_written, 64'd17);

    // Outstanding throttle: 6 singles with no responses.
    for (int i = 0; i < 6; i++) begin
      put(16'(16'h0400 + i), 16'(16'hB000 + i), 7'd1);
      step();
    end
    s_write = 1'b0;
    step(); step(); step();
    chk("thr_mwrite", 64'(m_write), 64'd0);
    chk("thr_level", 64'(fifo_level), 64'd2);
    chk("thr_outst", 64'(outstanding), 64'd4);
    chk("thr_head", 64'(m_address), 64'h404);
    m_wrrsp_valid = 1'b1;
    step();
    m_wrrsp_valid = 1'b0;
    chk("thr_rsp_outst", 64'(outstanding), 64'd3);
    chk("thr_rsp_mwrite", 64'(m_write), 64'd1);
    step();
    chk("thr_issue_outst", 64'(outstanding), 64'd4);
    chk("thr_issue_level", 64'(fifo_level), 64'd1);
    chk("thr_issue_mwrite", 64'(m_write), 64'd0);
    chk("thr_issue_head", 64'(m_address), 64'h405);

    // Queue a burst of 4 and a single behind the throttled head.
    for (int j = 0; j < 5; j++) begin
      if (j < 4) put(16'(16'h0500 + j), 16'(16'hC000 + j), 7'd4);
      else       put(16'h0600, 16'hC600, 7'd1);
      step();
    end
    s_write = 1'b0;
    chk("bq_level", 64'(fifo_level), 64'd6);
    chk("bq_mwrite", 64'(m_write), 64'd0);
    m_wrrsp_valid = 1'b1;
    step();
    m_wrrsp_valid = 1'b0;
    step();
    chk("b_pre_outst", 64'(outstanding), 64'd4);
    chk("b_pre_mwrite", 64'(m_write), 64'd0);
    chk("b_pre_head", 64'(m_address), 64'h500);
    m_wrrsp_valid = 1'b1;
    step();
    m_wrrsp_valid = 1'b0;
    chk("b_lim1_outst", 64'(outstanding), 64'd3);
    chk("b_lim1_mwrite", 64'(m_write), 64'd1);
    for (int j = 0; j < 4; j++) begin
      step();
      chk("burst_outst", 64'(outstanding), 64'd4);
      chk("burst_mwrite", 64'(m_write), 64'(j < 3));
      if (j < 3) chk("burst_addr", 64'(m_address), 64'(16'h0501 + j));
    end
    step();
    chk("sop_hold_a", 64'(m_write), 64'd0);
    step();
    chk("sop_hold_b", 64'(m_write), 64'd0);
    chk("sop_hold_head", 64'(m_address), 64'h600);
    m_wrrsp_valid = 1'b1;
    step();
    m_wrrsp_valid = 1'b0;
    chk("sop_rel_mwrite", 64'(m_write), 64'd1);
    step();
    chk("sop_rel_outst", 64'(outstanding), 64'd4);
    chk("sop_rel_level", 64'(fifo_level), 64'd0);

    // Same-cycle first-beat accept and response at outstanding==3.
    m_wrrsp_valid = 1'b1;
    step();
    m_wrrsp_valid = 1'b0;
    put(16'h0700, 16'hA700, 7'd1);
    step();
    s_write = 1'b0;
    chk("sc_pre_outst", 64'(outstanding), 64'd3);
    chk("sc_pre_mwrite", 64'(m_write), 64'd1);
    m_wrrsp_valid = 1'b1;
    step();
    chk("same_cyc_outst", 64'(outstanding), 64'd3);
    chk("same_cyc_level", 64'(fifo_level), 64'd0);
    step(); step(); step();
    chk("rsp_drain_outst", 64'(outstanding), 64'd0);
    step();
    m_wrrsp_valid = 1'b0;
    chk("rsp_at_zero", 64'(outstanding), 64'd0);
    chk("seqb_idle", 64'(idle), 64'd1);
    chk("seqb_bw", beats_written, 64'd29);

    // Reset in the middle of a partly queued burst.
    put(16'h07F0, 16'h1111, 7'd1);
    step();
    s_write = 1'b0;
    step();
    m_waitrequest = 1'b1;
    for (int j = 0; j < 5; j++) begin
      put(16'(16'h0800 + j), 16'(16'h2000 + j), 7'd8);
      step();
    end
    s_write = 1'b0;
    chk("prerst_level", 64'(fifo_level), 64'd5);
    chk("prerst_outst", 64'(outstanding), 64'd1);
    reset_n = 1'b0;
    step();
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_mwrite", 64'(m_write), 64'd0);
    chk("rst_outst", 64'(outstanding), 64'd0);
    chk("rst_bw", beats_written, 64'd0);
    chk("rst_swr", 64'(s_waitrequest), 64'd1);
    reset_n = 1'b1;
    m_waitrequest = 1'b0;
    step();
    chk("postrst_idle", 64'(idle), 64'd1);
    chk("postrst_swr", 64'(s_waitrequest), 64'd0);
    put(16'h0900, 16'h3333, 7'd1);
    step();
    s_write = 1'b0;
    chk("postrst_mwrite", 64'(m_write), 64'd1);
    chk("postrst_addr", 64'(m_address), 64'h900);
    step();
    chk("postrst_outst", 64'(outstanding), 64'd1);
    m_wrrsp_valid = 1'b1;
    step();
    m_wrrsp_valid = 1'b0;
    chk("postrst_rsp_outst", 64'(outstanding), 64'd0);
    chk("postrst_bw", beats_written, 64'd1);
    chk("postrst_final_idle", 64'(idle), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
